// File: rtl/pattern_history_table.sv
// Direct-mapped table of 2-bit saturating branch counters indexed by word-aligned PC.
// The table is swept to INIT_STATE after reset, then serves one lookup and one update per cycle.
module pattern_history_table #(
    parameter int         INDEX_BITS = 6,
    parameter int         PC_WIDTH   = 32,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    input  logic                  upd_valid,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic                  upd_taken,
    output logic                  ready,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [1:0]            pred_counter,
    output logic [INDEX_BITS-1:0] pred_index
);
    localparam int DEPTH = 2**INDEX_BITS;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t                r_state, w_state_nxt;
    logic [INDEX_BITS-1:0] r_init_ptr, w_init_ptr_nxt;
    logic [1:0]            r_table [DEPTH];

    logic                  r_pred_valid;
    logic [1:0]            r_pred_counter;
    logic [INDEX_BITS-1:0] r_pred_index;

    logic [INDEX_BITS-1:0] w_lk_idx, w_up_idx;
    logic                  w_lk_acc, w_up_acc;
    logic [1:0]            w_up_old, w_up_new, w_lk_val;
    logic                  w_unused_pc_bits;

    assign w_lk_idx = lookup_pc[INDEX_BITS+1:2];
    assign w_up_idx = upd_pc[INDEX_BITS+1:2];
    assign w_unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                                upd_pc[PC_WIDTH-1:INDEX_BITS+2], upd_pc[1:0]};

    assign ready    = (r_state == S_READY);
    assign w_lk_acc = lookup_valid && ready;
    assign w_up_acc = upd_valid && ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        if (r_state == S_INIT) begin
            w_init_ptr_nxt = r_init_ptr + 1'b1;
            if (r_init_ptr == {INDEX_BITS{1'b1}})
                w_state_nxt = S_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_ptr <= w_init_ptr_nxt;
        end
    end

    // Saturating counter step; no wrap in either direction.
    always_comb begin
        w_up_old = r_table[w_up_idx];
        w_up_new = w_up_old;
        if (upd_taken) begin
            if (w_up_old != 2'b11) w_up_new = w_up_old + 2'b01;
        end else begin
            if (w_up_old != 2'b00) w_up_new = w_up_old - 2'b01;
        end
    end

    // Same-index update forwards its post-update value to the lookup.
    assign w_lk_val = (w_up_acc && (w_up_idx == w_lk_idx)) ? w_up_new : r_table[w_lk_idx];

    // Single write port: the sweep only runs while not ready, updates only while ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT)
                r_table[r_init_ptr] <= INIT_STATE;
            else if (w_up_acc)
                r_table[w_up_idx] <= w_up_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid   <= 1'b0;
            r_pred_counter <= '0;
            r_pred_index   <= '0;
        end else begin
            r_pred_valid <= w_lk_acc;
            if (w_lk_acc) begin
                r_pred_counter <= w_lk_val;
                r_pred_index   <= w_lk_idx;
            end
        end
    end

    assign pred_valid   = r_pred_valid;
    assign pred_counter = r_pred_counter;
    assign pred_taken   = r_pred_counter[1];
    assign pred_index   = r_pred_index;
endmodule
